uart_cmd_master: RTL
====================

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 65535, CLK cycles allowed between response bytes in WAIT_RSP.
REQ-002 CLK  in  1  single clock for all logic.
REQ-003 RST  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  high only in IDLE.
REQ-006 cmd_op  in  2  command type: 00 reg write, 01 reg read, 10 ALU with operands, 11 ALU without operands.
REQ-007 cmd_addr  in  4  register address.
REQ-008 cmd_data  in  8  write data (op 00) or operand A (op 10).
REQ-009 cmd_opb  in  8  operand B (op 10).
REQ-010 cmd_func  in  4  ALU function (ops 10, 11).
REQ-011 tx_data  out  8  frame byte offered to the UART transmitter.
REQ-012 tx_valid  out  1  tx_data valid.
REQ-013 tx_ready  in  1  transmitter accepts tx_data this cycle.
REQ-014 rx_data  in  8  response byte from the UART receiver.
REQ-015 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-016 rsp_data  out  16  response value, held until the next response.
REQ-017 rsp_valid  out  1  one-cycle pulse: rsp_data updated.
REQ-018 rsp_timeout  out  1  one-cycle pulse: response abandoned.
REQ-019 cmd_done  out  1  one-cycle pulse on completion of any command, including timeout.

Function
REQ-020 States: IDLE, SEND, WAIT_RSP; a handshake cmd_valid&cmd_ready in IDLE registers all cmd_* fields, clears the byte index and enters SEND.
REQ-021 Frames: op00 = AA,addr,data; op01 = BB,addr; op10 = CC,A,B,func; op11 = DD,func; addr and func are zero-extended in bits [7:4].
REQ-022 In SEND, tx_valid is high and tx_data equals frame[index]; both are held stable until tx_ready; each tx_valid&tx_ready advances the index by one.
REQ-023 On acceptance of the last byte: op00 returns to IDLE with cmd_done next cycle and no rsp_valid; ops 01/10/11 enter WAIT_RSP with the rx byte count cleared.
REQ-024 In WAIT_RSP, op01 expects 1 byte, giving rsp_data = {8'h00, byte}; ops 10/11 expect 2 bytes, LSB first.
REQ-025 rsp_valid and cmd_done pulse the cycle after the final expected rx_valid, and the FSM returns to IDLE in that same cycle.
REQ-026 rx_valid outside WAIT_RSP is ignored, and no state changes.
REQ-027 A new command may be accepted the cycle after return to IDLE; back-to-back commands need no idle gap beyond that.
REQ-028 rsp_data is unchanged on timeout and on writes.

Reset
REQ-029 On RST: state IDLE, cmd_ready 1, tx_valid 0, tx_data 8'h00, rsp_data 16'h0000, rsp_valid/rsp_timeout/cmd_done 0, all counters and captured fields 0.
REQ-030 RST asserted mid-frame or mid-response aborts immediately, with no pulse outputs generated.

Configuration
REQ-031 With macro UART_CMD_MASTER_TIMEOUT_EN defined, a counter runs in WAIT_RSP, cleared on entry and on each rx_valid.
REQ-032 With the macro defined, when the counter reaches TIMEOUT_CYCLES-1 the block pulses rsp_timeout and cmd_done and returns to IDLE.
REQ-033 If rx_valid and timeout expiry coincide, rx_valid wins.
REQ-034 Without the macro, WAIT_RSP waits indefinitely, rsp_timeout is tied 0 and no counter logic exists.

Structure
REQ-035 Shared package uart_cmd_pkg holds the frame constants AA/BB/CC/DD, the cmd_op encodings, the state enum, and the expected-response-length per op.
REQ-036 One sub-module, cmd_timeout_cnt (counter, clear, expire flag), is instantiated only under UART_CMD_MASTER_TIMEOUT_EN; the FSM and frame mux stay in uart_cmd_master.

Verification
REQ-037 Write op00 addr 4'h5 data 8'h3C, tx_ready always 1 -> tx bytes AA,05,3C on three consecutive cycles, then cmd_done; no rsp_valid.
REQ-038 Read op01 addr 4'h2, respond 8'h7E -> tx bytes BB,02; rsp_data 16'h007E with rsp_valid one cycle after rx_valid.
REQ-039 ALU op10 A=8'h10, B=8'h20, func 4'h2; tx_ready toggling every other cycle; respond 8'h00,8'h02 -> tx bytes CC,10,20,02 each held until accepted; rsp_data 16'h0200.
REQ-040 Macro on, TIMEOUT_CYCLES=16, op11 func 4'h1, no response -> rsp_timeout and cmd_done exactly 16 cycles after WAIT_RSP entry; rsp_data unchanged.
REQ-041 RST pulsed after the second byte of op10 -> tx_valid 0 and cmd_ready 1 immediately; the following op01 frame is correct.
REQ-042 A stray rx_valid 8'hFF while in IDLE, followed by op01 with response 8'h11 -> rsp_data 16'h0011.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: frame headers, op encodings, FSM states and frame/response helpers for uart_cmd_master.
package uart_cmd_pkg;

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP} state_e;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;
    localparam logic [1:0] OP_ALU0 = 2'b11;

    localparam logic [7:0] HDR_WR   = 8'hAA;
    localparam logic [7:0] HDR_RD   = 8'hBB;
    localparam logic [7:0] HDR_ALU  = 8'hCC;
    localparam logic [7:0] HDR_ALU0 = 8'hDD;

    function automatic logic [1:0] frame_last(input logic [1:0] op);
        return op == OP_WR ? 2'd2 : op == OP_ALU ? 2'd3 : 2'd1;
    endfunction

    function automatic logic [1:0] rsp_len(input logic [1:0] op);
        return op == OP_WR ? 2'd0 : op == OP_RD ? 2'd1 : 2'd2;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [1:0] op, input logic [3:0] addr,
                                              input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] func, input logic [1:0] idx);
        case (op)
            OP_WR:   return idx == 2'd0 ? HDR_WR : idx == 2'd1 ? {4'h0, addr} : a;
            OP_RD:   return idx == 2'd0 ? HDR_RD : {4'h0, addr};
            OP_ALU:  return idx == 2'd0 ? HDR_ALU : idx == 2'd1 ? a : idx == 2'd2 ? b : {4'h0, func};
            default: return idx == 2'd0 ? HDR_ALU0 : {4'h0, func};
        endcase
    endfunction

endpackage

// File: rtl/cmd_timeout_cnt.sv
// cmd_timeout_cnt: cycle counter with clear, flags expiry when it reaches CYCLES-1 while enabled.
module cmd_timeout_cnt #(
    parameter int CYCLES = 65535
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);
    localparam int W = CYCLES > 1 ? $clog2(CYCLES) : 1;
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= cnt_q + W'(1);
    assign expire_o = en_i && cnt_q == W'(CYCLES - 1);
endmodule

// File: rtl/uart_cmd_master.sv
// uart_cmd_master: serialises commands into UART frames and collects the response bytes.
// Define UART_CMD_MASTER_TIMEOUT_EN to abandon responses after TIMEOUT_CYCLES idle cycles.
module uart_cmd_master
    import uart_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    input  logic [7:0]  cmd_opb,
    input  logic [3:0]  cmd_func,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_valid,
    output logic        rsp_timeout,
    output logic        cmd_done
);
    state_e      state_q;
    logic [1:0]  op_q, idx_q;
    logic [3:0]  addr_q, func_q;
    logic [7:0]  data_q, opb_q, lsb_q, tx_data_q;
    logic        rxn_q, tx_valid_q, rsp_valid_q, cmd_done_q;
    logic [15:0] rsp_data_q;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
    logic expire, tmo_q;
    cmd_timeout_cnt #(.CYCLES(TIMEOUT_CYCLES)) u_tmo (
        .clk      (CLK),
        .rst      (RST),
        .en_i     (state_q == WAIT_RSP),
        .clr_i    (state_q != WAIT_RSP || rx_valid),
        .expire_o (expire)
    );
    assign rsp_timeout = tmo_q;
`else
    // TIMEOUT_CYCLES is irrelevant here; the comparison is constant false
    assign rsp_timeout = TIMEOUT_CYCLES < 0;
`endif
    assign cmd_ready = state_q == IDLE;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_valid = rsp_valid_q;
    assign cmd_done  = cmd_done_q;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            op_q        <= '0;
            idx_q       <= '0;
            addr_q      <= '0;
            func_q      <= '0;
            data_q      <= '0;
            opb_q       <= '0;
            lsb_q       <= '0;
            rxn_q       <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            cmd_done_q  <= 1'b0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
            tmo_q       <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            cmd_done_q  <= 1'b0;
`ifdef UART_CMD_MASTER_TIMEOUT_EN
            tmo_q       <= 1'b0;
`endif
            case (state_q)
                IDLE: if (cmd_valid) begin
                    op_q       <= cmd_op;
                    addr_q     <= cmd_addr;
                    data_q     <= cmd_data;
                    opb_q      <= cmd_opb;
                    func_q     <= cmd_func;
                    idx_q      <= '0;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= frame_byte(cmd_op, cmd_addr, cmd_data, cmd_opb, cmd_func, 2'd0);
                    state_q    <= SEND;
                end
                SEND: if (tx_ready) begin
                    if (idx_q == frame_last(op_q)) begin
                        tx_valid_q <= 1'b0;
                        rxn_q      <= 1'b0;
                        cmd_done_q <= op_q == OP_WR;
                        state_q    <= op_q == OP_WR ? IDLE : WAIT_RSP;
                    end else begin
                        idx_q     <= idx_q + 2'd1;
                        tx_data_q <= frame_byte(op_q, addr_q, data_q, opb_q, func_q, idx_q + 2'd1);
                    end
                end
                WAIT_RSP: if (rx_valid) begin
                    if ({1'b0, rxn_q} == rsp_len(op_q) - 2'd1) begin
                        rsp_data_q  <= op_q == OP_RD ? {8'h00, rx_data} : {rx_data, lsb_q};
                        rsp_valid_q <= 1'b1;
                        cmd_done_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        lsb_q <= rx_data;
                        rxn_q <= 1'b1;
                    end
                end
`ifdef UART_CMD_MASTER_TIMEOUT_EN
                else if (expire) begin
                    tmo_q      <= 1'b1;
                    cmd_done_q <= 1'b1;
                    state_q    <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
